// File: rtl/trap_ctrl_pkg.sv
// Shared types and constants for the machine-mode trap sequencer.
// Optional mtval write-back is enabled by defining TRAP_CTRL_TVAL_EN.
package trap_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DRAIN    = 3'd1,
    ST_COMMIT   = 3'd2,
    ST_TVAL     = 3'd3,
    ST_REDIRECT = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    EV_NONE = 2'd0,
    EV_EXC  = 2'd1,
    EV_MRET = 2'd2,
    EV_IRQ  = 2'd3
  } event_e;

  localparam logic [11:0] CSR_ADDR_MTVAL = 12'h343;

  localparam logic [3:0] IRQ_CODE_EXT = 4'd11;
  localparam logic [3:0] IRQ_CODE_SW  = 4'd3;
  localparam logic [3:0] IRQ_CODE_TMR = 4'd7;

  // Bit positions inside irq_pend / csr_mxie
  localparam int IRQ_BIT_EXT = 2;
  localparam int IRQ_BIT_SW  = 1;
  localparam int IRQ_BIT_TMR = 0;

  localparam logic [1:0] MTVEC_MODE_DIRECT = 2'b00;

  // Any non-direct mtvec mode vectors interrupts; exceptions always use the base.
  function automatic logic [31:0] redirect_target(
    input event_e      kind,
    input logic [31:0] mtvec,
    input logic [31:0] mepc,
    input logic [3:0]  code
  );
    logic [31:0] base;
    base = {mtvec[31:2], 2'b00};
    if (kind == EV_MRET) return mepc;
    if (kind == EV_IRQ && mtvec[1:0] != MTVEC_MODE_DIRECT)
      return base + {26'd0, code, 2'b00};
    return base;
  endfunction

endpackage

// File: rtl/trap_ctrl_irq_sel.sv
// Masked fixed-priority interrupt encoder: external > software > timer.
module trap_irq_sel
  import trap_ctrl_pkg::*;
(
  input  logic [2:0] i_irq_pend,
  input  logic [2:0] i_mxie,
  input  logic       i_mie,
  output logic       o_any,
  output logic [3:0] o_code
);

  logic [2:0] w_masked;

  assign w_masked = i_irq_pend & i_mxie & {3{i_mie}};
  assign o_any    = |w_masked;

  always_comb begin
    o_code = 4'd0;
    if (w_masked[IRQ_BIT_EXT])      o_code = IRQ_CODE_EXT;
    else if (w_masked[IRQ_BIT_SW])  o_code = IRQ_CODE_SW;
    else if (w_masked[IRQ_BIT_TMR]) o_code = IRQ_CODE_TMR;
  end

endmodule

// File: rtl/trap_ctrl.sv
// Trap sequencer: arbitrates exceptions, mret and interrupts, drains the pipe,
// strobes the CSR file and redirects fetch. TRAP_CTRL_TVAL_EN adds the mtval write.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            ctrl_clk,
  input  logic            ctrl_reset_n,
  input  logic            exc_valid,
  input  logic [3:0]      exc_cause,
  input  logic [XLEN-1:0] exc_pc,
  input  logic [XLEN-1:0] exc_tval,
  input  logic            mret_valid,
  input  logic [XLEN-1:0] irq_pc,
  input  logic            pipe_idle,
  input  logic [2:0]      irq_pend,
  input  logic            csr_mie,
  input  logic [2:0]      csr_mxie,
  input  logic [XLEN-1:0] csr_mtvec,
  input  logic [XLEN-1:0] csr_mepc,
  input  logic            core_csr_wen,
  input  logic [11:0]     core_csr_waddr,
  input  logic [XLEN-1:0] core_csr_wdata,
  output logic            core_csr_ready,
  output logic            csr_wen,
  output logic [11:0]     csr_waddr,
  output logic [XLEN-1:0] csr_wdata,
  output logic            csr_trap,
  output logic            csr_mret,
  output logic [XLEN-1:0] csr_trap_pc,
  output logic [4:0]      csr_trap_info,
  output logic            stall,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            ack
);

  state_e          r_state;
  event_e          r_kind;
  logic [3:0]      r_cause;
  logic [XLEN-1:0] r_pc;
  logic            r_csr_trap;
  logic            r_csr_mret;
  logic [XLEN-1:0] r_trap_pc;
  logic [4:0]      r_trap_info;
  logic            r_stall;
  logic            r_redirect_valid;
  logic [XLEN-1:0] r_redirect_pc;
  logic            r_ack;
  logic            r_tval_wen;

  logic            w_irq_any;
  logic [3:0]      w_irq_code;
  logic            w_idle;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_tval_data;

`ifdef TRAP_CTRL_TVAL_EN
  logic [XLEN-1:0] r_tval;
  logic [XLEN-1:0] r_target;
  assign w_tval_data = r_tval;
`else
  logic w_unused_tval;
  assign w_unused_tval = ^exc_tval;
  assign w_tval_data   = '0;
`endif

  trap_irq_sel u_irq_sel (
    .i_irq_pend (irq_pend),
    .i_mxie     (csr_mxie),
    .i_mie      (csr_mie),
    .o_any      (w_irq_any),
    .o_code     (w_irq_code)
  );

  // In COMMIT the interrupt code still sits in r_trap_info.
  assign w_target = redirect_target(r_kind, csr_mtvec, csr_mepc, r_trap_info[3:0]);

  always_ff @(posedge ctrl_clk or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      r_state          <= ST_IDLE;
      r_kind           <= EV_NONE;
      r_cause          <= '0;
      r_pc             <= '0;
      r_csr_trap       <= 1'b0;
      r_csr_mret       <= 1'b0;
      r_trap_pc        <= '0;
      r_trap_info      <= '0;
      r_stall          <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_ack            <= 1'b0;
      r_tval_wen       <= 1'b0;
`ifdef TRAP_CTRL_TVAL_EN
      r_tval           <= '0;
      r_target         <= '0;
`endif
    end else begin
      r_csr_trap       <= 1'b0;
      r_csr_mret       <= 1'b0;
      r_trap_pc        <= '0;
      r_trap_info      <= '0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_ack            <= 1'b0;
      r_tval_wen       <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (exc_valid || mret_valid || w_irq_any) begin
            r_state <= ST_DRAIN;
            r_stall <= 1'b1;
          end
          if (exc_valid) begin
            r_kind  <= EV_EXC;
            r_cause <= exc_cause;
            r_pc    <= exc_pc;
`ifdef TRAP_CTRL_TVAL_EN
            r_tval  <= exc_tval;
`endif
          end else if (mret_valid) begin
            r_kind <= EV_MRET;
          end else if (w_irq_any) begin
            r_kind <= EV_IRQ;
          end
        end
        ST_DRAIN: begin
          // A pending interrupt never blocks a synchronous exception.
          if (r_kind == EV_IRQ && exc_valid) begin
            r_kind  <= EV_EXC;
            r_cause <= exc_cause;
            r_pc    <= exc_pc;
`ifdef TRAP_CTRL_TVAL_EN
            r_tval  <= exc_tval;
`endif
          end else if (r_kind == EV_IRQ && !w_irq_any) begin
            r_state <= ST_IDLE;
            r_stall <= 1'b0;
            r_kind  <= EV_NONE;
          end else if (pipe_idle) begin
            r_state    <= ST_COMMIT;
            r_csr_trap <= 1'b1;
            r_csr_mret <= (r_kind == EV_MRET);
            if (r_kind == EV_EXC) begin
              r_trap_pc   <= r_pc;
              r_trap_info <= {1'b0, r_cause};
            end else if (r_kind == EV_IRQ) begin
              r_pc        <= irq_pc;
              r_trap_pc   <= irq_pc;
              r_trap_info <= {1'b1, w_irq_code};
            end
          end
        end
        ST_COMMIT: begin
`ifdef TRAP_CTRL_TVAL_EN
          if (r_kind == EV_EXC) begin
            r_state    <= ST_TVAL;
            r_tval_wen <= 1'b1;
            r_target   <= w_target;
          end else begin
            r_state          <= ST_REDIRECT;
            r_redirect_valid <= 1'b1;
            r_redirect_pc    <= w_target;
            r_ack            <= (r_kind != EV_IRQ);
          end
`else
          r_state          <= ST_REDIRECT;
          r_redirect_valid <= 1'b1;
          r_redirect_pc    <= w_target;
          r_ack            <= (r_kind != EV_IRQ);
`endif
        end
        ST_TVAL: begin
          r_state          <= ST_REDIRECT;
          r_redirect_valid <= 1'b1;
`ifdef TRAP_CTRL_TVAL_EN
          r_redirect_pc    <= r_target;
`endif
          r_ack            <= (r_kind != EV_IRQ);
        end
        ST_REDIRECT: begin
          r_state <= ST_IDLE;
          r_stall <= 1'b0;
          r_kind  <= EV_NONE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_stall <= 1'b0;
          r_kind  <= EV_NONE;
        end
      endcase
    end
  end

  // Core CSR writes own the port only while idle; otherwise only the mtval write uses it.
  assign w_idle         = (r_state == ST_IDLE);
  assign core_csr_ready = w_idle;
  assign csr_wen        = w_idle ? core_csr_wen   : r_tval_wen;
  assign csr_waddr      = w_idle ? core_csr_waddr : (r_tval_wen ? CSR_ADDR_MTVAL : 12'd0);
  assign csr_wdata      = w_idle ? core_csr_wdata : (r_tval_wen ? w_tval_data : '0);

  assign csr_trap       = r_csr_trap;
  assign csr_mret       = r_csr_mret;
  assign csr_trap_pc    = r_trap_pc;
  assign csr_trap_info  = r_trap_info;
  assign stall          = r_stall;
  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;
  assign ack            = r_ack;

endmodule
